counter_sweep_ctrl: RTL and testbench

//   Sequencer for the N-bit loadable up/down counter: drives its load_en, counter_in and up_down
//   to produce cfg_reps triangle sweeps lo->hi->lo, then holds the counter.

---
 rtl/counter_sweep_ctrl.sv | 141 ++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// Sequencer for a loadable up/down counter: runs cfg_reps triangle sweeps lo->hi->lo, then holds.
// Optional pause input enabled by defining SWEEP_PAUSE_EN.

module counter_sweep_ctrl #(
    parameter int unsigned CNT_WIDTH = 3,
    parameter int unsigned REP_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] cfg_lo,
    input  logic [CNT_WIDTH-1:0] cfg_hi,
    input  logic [REP_WIDTH-1:0] cfg_reps,
`ifdef SWEEP_PAUSE_EN
    input  logic                 pause,
`endif
    input  logic [CNT_WIDTH-1:0] counter_out,
    output logic                 load_en,
    output logic [CNT_WIDTH-1:0] counter_in,
    output logic                 up_down,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [REP_WIDTH-1:0] sweep_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_UP   = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [REP_WIDTH-1:0] reps_q, reps_d, sweep_cnt_d;
    logic                 err_d;
    logic                 freeze;

`ifdef SWEEP_PAUSE_EN
    assign freeze = pause;
`else
    assign freeze = 1'b0;
`endif

    // State and latched configuration
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            reps_q    <= '0;
            sweep_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            reps_q    <= reps_d;
            sweep_cnt <= sweep_cnt_d;
            err       <= err_d;
        end
    end

    // Next state and counter drive; the default is a self-load so the counter holds
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        reps_d      = reps_q;
        sweep_cnt_d = sweep_cnt;
        err_d       = 1'b0;
        load_en     = 1'b1;
        counter_in  = counter_out;
        up_down     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if ((cfg_lo >= cfg_hi) || (cfg_reps == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        lo_d        = cfg_lo;
                        hi_d        = cfg_hi;
                        reps_d      = cfg_reps;
                        sweep_cnt_d = '0;
                        state_d     = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    counter_in = lo_q;
                    state_d    = S_UP;
                end
            end
            S_UP: begin
                busy    = 1'b1;
                up_down = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!freeze) begin
                    load_en = 1'b0;
                    if (counter_out == (hi_q - CNT_WIDTH'(1))) begin
                        state_d = S_DOWN;
                    end
                end
            end
            S_DOWN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!freeze) begin
                    load_en = 1'b0;
                    // Counter reaches lo_q on this edge: one sweep complete
                    if (counter_out == (lo_q + CNT_WIDTH'(1))) begin
                        sweep_cnt_d = sweep_cnt + REP_WIDTH'(1);
                        if ((sweep_cnt + REP_WIDTH'(1)) == reps_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_UP;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: directed and random sweeps against a planned per-cycle trace and event scoreboard.
// Exercises the pause input when SWEEP_PAUSE_EN is defined.

module tb_counter_sweep_ctrl;

    localparam int unsigned CNT_WIDTH = 3;
    localparam int unsigned REP_WIDTH = 4;
`ifdef SWEEP_PAUSE_EN
    localparam bit HAS_PAUSE = 1'b1;
`else
    localparam bit HAS_PAUSE = 1'b0;
`endif

    localparam int EV_ERR   = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;

    logic                 clk;
    logic                 reset_n;
    logic                 start;
    logic                 abort;
    logic                 pause;
    logic [CNT_WIDTH-1:0] cfg_lo;
    logic [CNT_WIDTH-1:0] cfg_hi;
    logic [REP_WIDTH-1:0] cfg_reps;
    logic [CNT_WIDTH-1:0] counter_out;
    logic [CNT_WIDTH-1:0] counter_in;
    logic                 load_en;
    logic                 up_down;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [REP_WIDTH-1:0] sweep_cnt;

    typedef struct {
        int cnt;
        int ld;
        int ud;
    } step_t;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
        int sw;
    } ev_t;

    step_t tr_q[$];
    ev_t   ev_q[$];
    int    n_vec   = 0;
    int    n_err   = 0;
    int    cyc     = 0;
    int    cur_cnt = 0;

    counter_sweep_ctrl #(
        .CNT_WIDTH(CNT_WIDTH),
        .REP_WIDTH(REP_WIDTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .cfg_lo     (cfg_lo),
        .cfg_hi     (cfg_hi),
        .cfg_reps   (cfg_reps),
`ifdef SWEEP_PAUSE_EN
        .pause      (pause),
`endif
        .counter_out(counter_out),
        .load_en    (load_en),
        .counter_in (counter_in),
        .up_down    (up_down),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sweep_cnt  (sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The counter being sequenced: no enable, load has priority, async reset to 0
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     counter_out <= '0;
        else if (load_en) counter_out <= counter_in;
        else if (up_down) counter_out <= counter_out + 3'd1;
        else              counter_out <= counter_out - 3'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cfg();
        cfg_lo   = 3'($urandom);
        cfg_hi   = 3'($urandom);
        cfg_reps = 4'($urandom);
    endtask

    // Idle cycles: start is only raised together with abort, which must be ignored
    task automatic idle(input int n);
        repeat (n) begin
            abort = 1'($urandom);
            start = abort ? 1'($urandom) : 1'b0;
            pause = 1'($urandom);
            rand_cfg();
            step();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Issue one start in the current cycle and drive the whole run; the plan is the sweep as a value list
    task automatic issue(input int lo, input int hi, input int reps,
                         input int abort_at, input int pause_at, input int pause_len);
        step_t plan[$];
        step_t e;
        int    n0;
        int    i;
        int    paused;
        n0       = cyc;
        start    = 1'b1;
        abort    = 1'b0;
        pause    = 1'($urandom);
        cfg_lo   = 3'(lo);
        cfg_hi   = 3'(hi);
        cfg_reps = 4'(reps);
        if (lo >= hi || reps == 0) begin
            ev_q.push_back('{EV_ERR, n0 + 1, 0, 0});
            step();
            start = 1'b0;
            rand_cfg();
            return;
        end
        plan.push_back('{cur_cnt, 1, 0});
        for (int r = 0; r < reps; r++) begin
            for (int v = lo; v < hi; v++) plan.push_back('{v, 0, 1});
            for (int v = hi; v > lo; v--) plan.push_back('{v, 0, 0});
        end
        step();
        i      = 0;
        paused = 0;
        while (i < plan.size()) begin
            start = 1'($urandom);
            abort = 1'b0;
            pause = 1'b0;
            rand_cfg();
            e = plan[i];
            if (i == abort_at) begin
                abort = 1'b1;
                e.ld  = 1;
                tr_q.push_back(e);
                ev_q.push_back('{EV_ABORT, cyc + 1, e.cnt, 0});
                cur_cnt = e.cnt;
                step();
                start = 1'b0;
                abort = 1'b0;
                return;
            end
            if (HAS_PAUSE && i >= 1 && i == pause_at && paused < pause_len) begin
                pause = 1'b1;
                e.ld  = 1;
                paused++;
                tr_q.push_back(e);
                step();
                continue;
            end
            if (i == 0) pause = 1'($urandom);
            tr_q.push_back(e);
            i++;
            step();
        end
        ev_q.push_back('{EV_DONE, n0 + 2 + 2 * (hi - lo) * reps + paused, lo, reps});
        start = 1'($urandom);
        abort = 1'($urandom);
        pause = 1'($urandom);
        rand_cfg();
        cur_cnt = lo;
        step();
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
    endtask

    // Monitor: per-cycle trace while busy, hold check while idle, events on done/err/busy drop
    bit    prev_busy;
    int    prev_cnt;
    step_t mon_e;
    ev_t   mon_x;

    function automatic void pop_event(input int kind);
        if (ev_q.size() == 0) begin
            check("event_unexpected", 1, 0);
            return;
        end
        mon_x = ev_q.pop_front();
        check("event_kind", kind, mon_x.kind);
        check("event_cycle", cyc, mon_x.cyc);
        if (kind != EV_ERR) check("event_counter", int'(counter_out), mon_x.cnt);
        if (kind == EV_DONE) check("done_sweep_cnt", int'(sweep_cnt), mon_x.sw);
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
            prev_cnt  = 0;
        end else begin
            if (busy) begin
                if (tr_q.size() == 0) begin
                    check("trace_unexpected_busy", 1, 0);
                end else begin
                    mon_e = tr_q.pop_front();
                    check("trace_counter", int'(counter_out), mon_e.cnt);
                    check("trace_load_en", int'(load_en), mon_e.ld);
                    check("trace_up_down", int'(up_down), mon_e.ud);
                end
                if (done) check("done_while_busy", 1, 0);
            end else begin
                check("idle_load_en", int'(load_en), 1);
                if (!prev_busy) begin
                    check("idle_hold", int'(counter_out), prev_cnt);
                    if (done) check("done_without_run", 1, 0);
                end else begin
                    pop_event(done ? EV_DONE : EV_ABORT);
                end
            end
            if (err) pop_event(EV_ERR);
            prev_busy = busy;
            prev_cnt  = int'(counter_out);
        end
    end

    initial begin
        int lo;
        int hi;
        int reps;
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        pause    = 1'b0;
        cfg_lo   = '0;
        cfg_hi   = '0;
        cfg_reps = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_counter", int'(counter_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        check("reset_sweep_cnt", int'(sweep_cnt), 0);
        check("reset_up_down", int'(up_down), 0);
        check("reset_load_en", int'(load_en), 1);
        #2 reset_n = 1'b1;
        step();
        idle(5);

        issue(1, 3, 1, -1, -1, 0);
        idle(2);
        issue(0, 7, 2, -1, -1, 0);
        idle(2);
        issue(5, 5, 1, -1, -1, 0);
        issue(2, 6, 0, -1, -1, 0);
        idle(2);
        issue(2, 6, 3, 3, -1, 0);
        idle(3);
        issue(2, 6, 1, -1, -1, 0);
        idle(1);
        issue(1, 5, 1, -1, 7, 3);
        idle(2);

        repeat (60) begin
            lo   = int'($urandom_range(0, 7));
            hi   = int'($urandom_range(0, 7));
            reps = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) hi = lo;
            issue(lo, hi, reps,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1,
                  int'($urandom_range(1, 30)), int'($urandom_range(1, 4)));
            idle(int'($urandom_range(0, 3)));
        end

        idle(4);
        check("trace_drained", tr_q.size(), 0);
        check("events_drained", ev_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
